// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-SRAM arbiter.
// Holds the read-owner enum, the read tag and the byte address width.
package dmem_arb_pkg;

    localparam int DMEM_BYTE_AW = 16;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   zero;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arb_age.sv
// dmem_arb_age: starvation guard for the low-priority requester.
// Ports: clk, rstn (async, active-high), req, gnt in; promote out.
module dmem_arb_age #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic req,
    input  logic gnt,
    output logic promote
);

    localparam logic [7:0] MAX = 8'(MAX_WAIT);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cnt <= '0;
        end else if (gnt) begin
            cnt <= '0;
        end else if (req && cnt != MAX) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign promote = (cnt == MAX);

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: two-requester arbiter for the single-port data SRAM.
// Ports: m0_*/m1_* requesters, sram_* SRAM side, err, perf_* counters.
// Build option: DMEM_ARB_PERF_EN enables the perf counter flops.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 14,
    parameter int MAX_WAIT = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    m0_req,
    input  logic [DMEM_BYTE_AW-1:0] m0_a,
    input  logic [3:0]              m0_we,
    input  logic [31:0]             m0_wd,
    input  logic [3:0]              m0_re,
    output logic                    m0_gnt,
    output logic [31:0]             m0_rd,
    output logic                    m0_rvld,
    input  logic                    m1_req,
    input  logic [DMEM_BYTE_AW-1:0] m1_a,
    input  logic [3:0]              m1_we,
    input  logic [31:0]             m1_wd,
    input  logic [3:0]              m1_re,
    output logic                    m1_gnt,
    output logic [31:0]             m1_rd,
    output logic                    m1_rvld,
    output logic [AW-1:0]           sram_a,
    output logic [3:0]              sram_we,
    output logic [31:0]             sram_wd,
    output logic [3:0]              sram_re,
    input  logic [31:0]             sram_rd,
    output logic                    err,
    output logic [31:0]             perf_gnt0,
    output logic [31:0]             perf_gnt1,
    output logic [31:0]             perf_conflict
);

    // Byte-address bits above the SRAM window flag an out-of-range access.
    localparam logic [DMEM_BYTE_AW-1:0] HI_MASK =
        DMEM_BYTE_AW'(~((32'd1 << (AW + 2)) - 32'd1));

    logic                    promote;
    logic                    sel0;
    logic                    sel1;
    logic                    active;
    logic                    oor;
    logic [DMEM_BYTE_AW-1:0] cmd_a;
    logic [3:0]              cmd_we;
    logic [31:0]             cmd_wd;
    logic [3:0]              cmd_re;
    logic [3:0]              re_eff;
    rd_tag_t                 tag;
    logic                    unused_bits;

    dmem_arb_age #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk     (clk),
        .rstn    (rstn),
        .req     (m1_req),
        .gnt     (m1_gnt),
        .promote (promote)
    );

    // Grants are suppressed while reset is held so the SRAM stays quiet.
    assign sel1   = !rstn && m1_req && (promote || !m0_req);
    assign sel0   = !rstn && m0_req && !sel1;
    assign active = sel0 || sel1;
    assign m0_gnt = sel0;
    assign m1_gnt = sel1;

    assign cmd_a  = sel1 ? m1_a  : m0_a;
    assign cmd_we = sel1 ? m1_we : m0_we;
    assign cmd_wd = sel1 ? m1_wd : m0_wd;
    assign cmd_re = sel1 ? m1_re : m0_re;

    assign oor    = active && ((cmd_a & HI_MASK) != '0);
    // A write wins over a read carried in the same command.
    assign re_eff = (cmd_we != 4'd0) ? 4'd0 : cmd_re;

    assign sram_a  = active ? cmd_a[AW+1:2] : '0;
    assign sram_wd = active ? cmd_wd : '0;
    assign sram_we = (active && !oor) ? cmd_we : 4'd0;
    assign sram_re = (active && !oor) ? re_eff : 4'd0;
    assign err     = oor;

    assign unused_bits = ^cmd_a[1:0];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            tag <= '0;
        end else begin
            tag <= '{valid: active && (re_eff != 4'd0),
                     owner: sel1 ? OWN_M1 : OWN_M0,
                     zero:  oor};
        end
    end

    assign m0_rvld = tag.valid && (tag.owner == OWN_M0);
    assign m1_rvld = tag.valid && (tag.owner == OWN_M1);
    assign m0_rd   = (m0_rvld && !tag.zero) ? sram_rd : '0;
    assign m1_rd   = (m1_rvld && !tag.zero) ? sram_rd : '0;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            perf_gnt0     <= '0;
            perf_gnt1     <= '0;
            perf_conflict <= '0;
        end else begin
            if (sel0) perf_gnt0 <= perf_gnt0 + 32'd1;
            if (sel1) perf_gnt1 <= perf_gnt1 + 32'd1;
            if (m0_req && m1_req) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`else
    assign perf_gnt0     = '0;
    assign perf_gnt1     = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: self-checking bench for dmem_arb with an SRAM model.
// Read responses are predicted into a scoreboard queue and popped on rvld.
module tb_dmem_arb;

    localparam int AW = 10;
    localparam int MAX_WAIT = 8;

    typedef struct {
        bit          own;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_req, m1_req;
    logic [15:0] m0_a, m1_a;
    logic [3:0]  m0_we, m1_we, m0_re, m1_re;
    logic [31:0] m0_wd, m1_wd;
    logic        m0_gnt, m1_gnt, m0_rvld, m1_rvld;
    logic [31:0] m0_rd, m1_rd;
    logic [AW-1:0] sram_a;
    logic [3:0]  sram_we, sram_re;
    logic [31:0] sram_wd;
    logic [31:0] sram_rd = '0;
    logic        err;
    logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;

    logic [31:0] mem [1024] = '{default: '0};

    int   n_cmp = 0;
    int   n_err = 0;
    rsp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (sram_we[b]) mem[sram_a][8*b +: 8] <= sram_wd[8*b +: 8];
        end
        if (|sram_re) sram_rd <= mem[sram_a];
    end

    dmem_arb #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_a(m0_a), .m0_we(m0_we), .m0_wd(m0_wd),
        .m0_re(m0_re), .m0_gnt(m0_gnt), .m0_rd(m0_rd), .m0_rvld(m0_rvld),
        .m1_req(m1_req), .m1_a(m1_a), .m1_we(m1_we), .m1_wd(m1_wd),
        .m1_re(m1_re), .m1_gnt(m1_gnt), .m1_rd(m1_rd), .m1_rvld(m1_rvld),
        .sram_a(sram_a), .sram_we(sram_we), .sram_wd(sram_wd),
        .sram_re(sram_re), .sram_rd(sram_rd), .err(err),
        .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1),
        .perf_conflict(perf_conflict)
    );

    task automatic set_m0(input logic r, input logic [15:0] a,
                          input logic [3:0] we, input logic [31:0] wd,
                          input logic [3:0] re);
        m0_req = r; m0_a = a; m0_we = we; m0_wd = wd; m0_re = re;
    endtask

    task automatic set_m1(input logic r, input logic [15:0] a,
                          input logic [3:0] we, input logic [31:0] wd,
                          input logic [3:0] re);
        m1_req = r; m1_a = a; m1_we = we; m1_wd = wd; m1_re = re;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        set_m0(1'b1, 16'h0028, 4'h0, 32'h0, 4'hF);
        set_m1(1'b1, 16'h0004, 4'hF, 32'h1234_5678, 4'h0);
        #1;
        n_cmp++;
        if ({m0_gnt, m1_gnt, m0_rvld, m1_rvld, err} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {m0_gnt, m1_gnt, m0_rvld, m1_rvld, err});
        end
        n_cmp++;
        if ({sram_a, sram_we, sram_re, sram_wd} !== '0) begin
            n_err++;
            $display("FAIL reset_sram: a=%h we=%h re=%h wd=%h want 0",
                     sram_a, sram_we, sram_re, sram_wd);
        end
        n_cmp++;
        if ({perf_gnt0, perf_gnt1, perf_conflict} !== '0) begin
            n_err++;
            $display("FAIL reset_perf: %h %h %h want 0",
                     perf_gnt0, perf_gnt1, perf_conflict);
        end
        @(negedge clk);
        set_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        set_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic test_m0_read();
        rsp_t e;
        @(negedge clk);
        set_m0(1'b1, 16'h0028, 4'hF, 32'hDEAD_BEEF, 4'h0);
        #1;
        n_cmp++;
        if ({m0_gnt, m1_gnt, sram_we, sram_re} !== {2'b10, 4'hF, 4'h0}) begin
            n_err++;
            $display("FAIL m0_wr_issue: gnt=%b%b we=%h re=%h want 10 F 0",
                     m0_gnt, m1_gnt, sram_we, sram_re);
        end
        @(negedge clk);
        set_m0(1'b1, 16'h0028, 4'h0, 32'h0, 4'hF);
        #1;
        n_cmp++;
        if ({m0_rvld, m1_rvld} !== 2'b00) begin
            n_err++;
            $display("FAIL m0_wr_no_rvld: got %b%b want 00",
                     m0_rvld, m1_rvld);
        end
        n_cmp++;
        if ({m0_gnt, sram_a, sram_re} !== {1'b1, 10'd10, 4'hF}) begin
            n_err++;
            $display("FAIL m0_rd_issue: gnt=%b a=%0d re=%h want 1 10 F",
                     m0_gnt, sram_a, sram_re);
        end
        sb.push_back('{own: 1'b0, data: 32'hDEAD_BEEF});
        @(negedge clk);
        set_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({m0_rvld, m1_rvld} !== (e.own ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL m0_rd_rvld: got %b%b own %0d",
                     m0_rvld, m1_rvld, e.own);
        end
        n_cmp++;
        if (m0_rd !== e.data) begin
            n_err++;
            $display("FAIL m0_rd_data: got %h want %h", m0_rd, e.data);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({m0_rvld, m1_rvld} !== 2'b00) begin
            n_err++;
            $display("FAIL m0_rd_single: got %b%b want 00",
                     m0_rvld, m1_rvld);
        end
    endtask

    task automatic test_byte_write();
        rsp_t e;
        @(negedge clk);
        set_m1(1'b1, 16'h0004, 4'h2, 32'h0000_AB00, 4'hF);
        #1;
        n_cmp++;
        if ({m0_gnt, m1_gnt, sram_we, sram_re, sram_a, sram_wd} !==
            {2'b01, 4'h2, 4'h0, 10'd1, 32'h0000_AB00}) begin
            n_err++;
            $display("FAIL bw_issue: gnt=%b%b we=%h re=%h a=%0d wd=%h",
                     m0_gnt, m1_gnt, sram_we, sram_re, sram_a, sram_wd);
        end
        @(negedge clk);
        set_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        set_m0(1'b1, 16'h0004, 4'h0, 32'h0, 4'hF);
        #1;
        n_cmp++;
        if ({m0_rvld, m1_rvld} !== 2'b00) begin
            n_err++;
            $display("FAIL bw_no_rvld: got %b%b want 00", m0_rvld, m1_rvld);
        end
        sb.push_back('{own: 1'b0, data: 32'h0000_AB00});
        @(negedge clk);
        set_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({m0_rvld, m1_rvld} !== (e.own ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL bw_rvld: got %b%b own %0d",
                     m0_rvld, m1_rvld, e.own);
        end
        n_cmp++;
        if (m0_rd !== e.data) begin
            n_err++;
            $display("FAIL bw_data: got %h want %h", m0_rd, e.data);
        end
    endtask

    task automatic test_out_of_range();
        rsp_t e;
        @(negedge clk);
        set_m0(1'b1, 16'hFFFC, 4'h0, 32'h0, 4'hF);
        #1;
        n_cmp++;
        if ({m0_gnt, err, sram_re, sram_we} !== {2'b11, 4'h0, 4'h0}) begin
            n_err++;
            $display("FAIL oor_issue: gnt=%b err=%b re=%h we=%h",
                     m0_gnt, err, sram_re, sram_we);
        end
        sb.push_back('{own: 1'b0, data: 32'h0});
        @(negedge clk);
        set_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({m0_rvld, m1_rvld, err} !== {(e.own ? 2'b01 : 2'b10), 1'b0}) begin
            n_err++;
            $display("FAIL oor_rvld: rvld=%b%b err=%b",
                     m0_rvld, m1_rvld, err);
        end
        n_cmp++;
        if (m0_rd !== e.data) begin
            n_err++;
            $display("FAIL oor_data: got %h want %h", m0_rd, e.data);
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e;
        @(negedge clk);
        set_m0(1'b1, 16'h0028, 4'h0, 32'h0, 4'hF);
        sb.push_back('{own: 1'b0, data: 32'hDEAD_BEEF});
        @(negedge clk);
        set_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        set_m1(1'b1, 16'h0004, 4'h0, 32'h0, 4'hF);
        sb.push_back('{own: 1'b1, data: 32'h0000_AB00});
        #1;
        n_cmp++;
        if ({m0_gnt, m1_gnt, sram_a} !== {2'b01, 10'd1}) begin
            n_err++;
            $display("FAIL b2b_issue: gnt=%b%b a=%0d", m0_gnt, m1_gnt, sram_a);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                @(negedge clk);
                set_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
                #1;
            end
            e = sb.pop_front();
            n_cmp++;
            if ({m0_rvld, m1_rvld} !== (e.own ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL b2b_rvld%0d: got %b%b own %0d",
                         k, m0_rvld, m1_rvld, e.own);
            end
            n_cmp++;
            if ((e.own ? m1_rd : m0_rd) !== e.data) begin
                n_err++;
                $display("FAIL b2b_data%0d: got %h want %h", k,
                         (e.own ? m1_rd : m0_rd), e.data);
            end
        end
    endtask

    task automatic test_starvation();
        logic [1:0] exp;
        @(negedge clk);
        set_m0(1'b1, 16'h0, 4'h0, 32'h0, 4'h0);
        set_m1(1'b1, 16'h0, 4'h0, 32'h0, 4'h0);
        for (int c = 1; c <= 27; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            exp = (c % (MAX_WAIT + 1) == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if ({m0_gnt, m1_gnt} !== exp) begin
                n_err++;
                $display("FAIL starve_c%0d: gnt=%b%b want %b",
                         c, m0_gnt, m1_gnt, exp);
            end
        end
        @(negedge clk);
        set_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        set_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        set_m1(1'b1, 16'h0028, 4'h0, 32'h0, 4'hF);
        sb.push_back('{own: 1'b1, data: 32'hDEAD_BEEF});
        #1;
        n_cmp++;
        if (m1_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rmr_gnt: got %b want 1", m1_gnt);
        end
        @(posedge clk);
        set_m0(1'b1, 16'h0004, 4'hF, 32'hFFFF_FFFF, 4'h0);
        #1;
        rstn = 1'b1;
        #1;
        sb.delete();
        n_cmp++;
        if ({m0_rvld, m1_rvld, m0_gnt, m1_gnt, err} !== 5'b0) begin
            n_err++;
            $display("FAIL rmr_ctl: rvld=%b%b gnt=%b%b err=%b want 0",
                     m0_rvld, m1_rvld, m0_gnt, m1_gnt, err);
        end
        n_cmp++;
        if ({sram_a, sram_we, sram_re, sram_wd, m1_rd} !== '0) begin
            n_err++;
            $display("FAIL rmr_sram: a=%h we=%h re=%h wd=%h rd=%h want 0",
                     sram_a, sram_we, sram_re, sram_wd, m1_rd);
        end
        @(negedge clk);
        set_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        set_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({m0_rvld, m1_rvld} !== 2'b00) begin
            n_err++;
            $display("FAIL rmr_after: rvld=%b%b want 00", m0_rvld, m1_rvld);
        end
    endtask

    task automatic test_perf();
        logic [95:0] exp;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_m0(i < 5, 16'h0, 4'h0, 32'h0, 4'h0);
            set_m1(1'b1, 16'h0, 4'h0, 32'h0, 4'h0);
        end
        @(negedge clk);
        set_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        set_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        #1;
`ifdef DMEM_ARB_PERF_EN
        exp = {32'd5, 32'd3, 32'd5};
`else
        exp = '0;
`endif
        n_cmp++;
        if ({perf_gnt0, perf_gnt1, perf_conflict} !== exp) begin
            n_err++;
            $display("FAIL perf: g0=%0d g1=%0d cf=%0d want %0d %0d %0d",
                     perf_gnt0, perf_gnt1, perf_conflict,
                     exp[95:64], exp[63:32], exp[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_byte_write();
        test_out_of_range();
        test_back_to_back();
        test_starvation();
        test_reset_mid_read();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
